// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  // Control states of the serial subtract sequence.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the bit index for an operand of the given width.
  function automatic int idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_IDX_W = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: diff = a - b - borrowin, with borrow out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic borrowin,
  output logic diff,
  output logic borrowout
);

  assign diff      = a ^ b ^ borrowin;
  // Borrow when b exceeds a, or when they are equal and a borrow is pending.
  assign borrowout = (~a & b) | (~(a ^ b) & borrowin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: difference = a - b, LSB first,
// one bit per clock, with a start/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrowout,
  output logic             overflow
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic             ov_q, ov_d;

  logic accept;
  logic last_bit;
  logic di;
  logic br_next;

  // Single shared bit slice operating on the operand LSBs.
  full_subtractor_bit u_bit (
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .borrowin (br_q),
    .diff     (di),
    .borrowout(br_next)
  );

  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit = (state_q == RUN) && (idx_q == LAST_IDX);

  // Next-state logic: accept from IDLE/DONE, run WIDTH bits, pulse DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle.
  always_comb begin
    idx_d  = idx_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    res_d  = res_q;
    br_d   = br_q;
    bo_d   = bo_q;
    ov_d   = ov_q;
    if (accept) begin
      idx_d  = '0;
      a_sh_d = a;
      b_sh_d = b;
      res_d  = '0;
      br_d   = 1'b0;
      bo_d   = 1'b0;
      ov_d   = 1'b0;
    end else if (state_q == RUN) begin
      idx_d  = idx_q + 1'b1;
      a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
      res_d  = {di, res_q[WIDTH-1:1]};
      br_d   = br_next;
      if (last_bit) begin
        // On the last bit the shift-register LSBs are the original operand MSBs.
        bo_d = br_next;
        ov_d = (a_sh_q[0] != b_sh_q[0]) && (di != a_sh_q[0]);
      end
    end
  end

  // Datapath registers; reset clears any partial result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      bo_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      res_q  <= res_d;
      br_q   <= br_d;
      bo_q   <= bo_d;
      ov_q   <= ov_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign difference = res_q;
  assign borrowout  = bo_q;
  assign overflow   = ov_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, using a single registered borrow. It is the sequential complement to the team's one-bit full adder: the same per-bit logic, run in the subtract direction and iterated over a word with a start/done handshake. It is intended for area-constrained datapaths where a WIDTH-bit ripple subtractor is too large and a WIDTH-cycle latency is acceptable.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be at least 2.
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `reset_n`, input, 1: reset, **asynchronous, active-low**.
- `start`, input, 1: request a subtraction. Sampled only in IDLE or DONE.
- `a`, input, WIDTH: minuend. Captured on the accepting edge.
- `b`, input, WIDTH: subtrahend. Captured on the accepting edge.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: high for exactly one cycle, in DONE.
- `difference`, output, WIDTH: `a - b` mod 2^WIDTH. Valid from DONE onward and held until the next accepted start.
- `borrowout`, output, 1: unsigned borrow, meaning `a < b` unsigned.
- `overflow`, output, 1: signed overflow of `a - b`.

## Operation
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → RUN while bit index < WIDTH-1.
  - RUN → DONE on the edge that processes bit WIDTH-1.
  - DONE → RUN on `start`; otherwise DONE → IDLE.
- Accepting edge actions:
  - Load `a` and `b` into shift registers.
  - Clear the borrow register and the bit index.
  - Clear `difference`, `borrowout` and `overflow`.
- Each RUN edge processes the LSBs `ai`, `bi` of the shift registers with borrow `br`:
  - `di = ai ^ bi ^ br`
  - `br' = (~ai & bi) | (~(ai ^ bi) & br)`
  - Shift `di` into the result register from the MSB end.
  - Shift the operand registers right by one.
  - Increment the bit index.
- On the final RUN edge (bit WIDTH-1):
  - `borrowout` ← `br'`.
  - `overflow` ← `(a[W-1] != b[W-1]) && (d[W-1] != a[W-1])`, using the captured operand MSBs and the final result bit.
- `start` in RUN is ignored. Operands are not re-sampled.
- Outputs hold their values in IDLE.

## Timing
- Call the accepting edge E0.
  - RUN occupies the cycles following E0 through E(WIDTH-1).
  - Edge E(WIDTH) processes the last bit and enters DONE.
  - `done`=1 and the results are valid in the cycle after E(WIDTH). Latency is WIDTH edges from acceptance to `done`.
- Back-to-back: `start` high in DONE is accepted at the DONE edge. `done` drops and `busy` rises. Throughput is one result per WIDTH+1 cycles.
- Reset (`reset_n`=0 at any time, including mid-RUN):
  - Immediately: state IDLE, and `busy`, `done`, `difference`, `borrowout`, `overflow`, borrow register, shift registers and bit index all 0.
  - No partial result survives reset.
- After `reset_n` deasserts, the first `start` is accepted on the first rising edge at which it is sampled high.
- `a` and `b` may change freely after E0.

## Structure
- Shared package `serial_subtractor_pkg`:
  - State enum: IDLE, RUN, DONE.
  - Bit-index width localparam, derived as `$clog2(WIDTH)`.
- Sub-module `full_subtractor_bit`:
  - Combinational one-bit subtractor with ports `diff`, `borrowout`, `a`, `b`, `borrowin`.
  - Instantiated once in the datapath.
- The top level contains the FSM, bit counter, operand/result shift registers and borrow flop.

## Test plan
All scenarios use WIDTH=8.
- `a`=100, `b`=37, single pulse of `start` → after 8 edges `done`=1 for one cycle; `difference`=0x3F, `borrowout`=0, `overflow`=0.
- `a`=5, `b`=7 → `difference`=0xFE, `borrowout`=1, `overflow`=0.
- `a`=0x80, `b`=0x01 → `difference`=0x7F, `borrowout`=0, `overflow`=1. Also `a`=0x7F, `b`=0xFF → `difference`=0x80, `overflow`=1, `borrowout`=1.
- Start `a`=0x10, `b`=0x01; at RUN cycle 3 pulse `start` with `a`=0xFF, `b`=0xFF → ignored, result 0x0F. Then hold `start` in DONE with `a`=0xFF, `b`=0xFF → re-accepted immediately, next result 0x00, `borrowout`=0.
- Pull `reset_n` low between clock edges at RUN cycle 4 → all outputs 0 without waiting for a clock. Release, then start `a`=0, `b`=0 → `difference`=0, `done` after 8 edges.
- Random sweep over all 65536 operand pairs → every `difference`, `borrowout` and `overflow` matches the behavioural `a - b` model.
